operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 162 ++++++++++++++++
 tb/tb_operand_fetch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Purpose : operand fetch stage with register-file read, same-cycle write-back bypass and busy-bit scoreboard.
// Latency : 1 cycle from accept (in_valid && in_ready) to out_valid with registered operands.
// Backpr. : single output register; in_ready drops on hazard, flush, reset or a held entry that is not consumed.
//
// Ports:
//   clk, rst                    sole clock and synchronous active-high reset
//   in_valid/in_ready           upstream handshake; in_rs1/in_rs2/in_rd/in_rd_wr/in_payload instruction fields
//   rf_a1/rf_a2, rf_rd1/rf_rd2  register file read address out, combinational read data in
//   wb_en/wb_addr/wb_data       write-back port (bypass source and scoreboard clear)
//   flush                       drop the held instruction and release its destination
//   out_valid/out_ready         downstream handshake; out_op1/out_op2/out_rd/out_rd_wr/out_payload held fields
//   stall_cnt                   saturating count of cycles an instruction waited on a hazard
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wr,
    input  logic [31:0]     in_payload,
    output logic [4:0]      rf_a1,
    output logic [4:0]      rf_a2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [4:0]      out_rd,
    output logic            out_rd_wr,
    output logic [31:0]     out_payload,
    output logic [15:0]     stall_cnt
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [4:0]      r_rd;
    logic            r_rd_wr;
    logic [31:0]     r_payload;
    logic [15:0]     r_stall_cnt;

    logic            w_wb_rs1;
    logic            w_wb_rs2;
    logic            w_wb_rd;
    logic            w_haz_rs1;
    logic            w_haz_rs2;
    logic            w_haz_rd;
    logic            w_hazard;
    logic            w_in_ready;
    logic            w_accept;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    assign rf_a1 = in_rs1;
    assign rf_a2 = in_rs2;

    // A write-back landing this cycle both supplies the value and retires the busy bit,
    // so it cancels the hazard on that register.
    assign w_wb_rs1 = wb_en && (wb_addr == in_rs1);
    assign w_wb_rs2 = wb_en && (wb_addr == in_rs2);
    assign w_wb_rd  = wb_en && (wb_addr == in_rd);

    // busy[0] is held at zero, so x0 sources can never hazard.
    assign w_haz_rs1 = r_busy[in_rs1] && !w_wb_rs1;
    assign w_haz_rs2 = r_busy[in_rs2] && !w_wb_rs2;
    assign w_haz_rd  = in_rd_wr && (in_rd != 5'd0) && r_busy[in_rd] && !w_wb_rd;
    assign w_hazard  = w_haz_rs1 || w_haz_rs2 || w_haz_rd;

    assign w_in_ready = !rst && !flush && !w_hazard && ((r_state == ST_EMPTY) || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    assign w_op1 = (in_rs1 == 5'd0) ? '0 : (w_wb_rs1 ? wb_data : rf_rd1);
    assign w_op2 = (in_rs2 == 5'd0) ? '0 : (w_wb_rs2 ? wb_data : rf_rd2);

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
            w_state_nxt = ST_FULL;
        end else if (out_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Clears are applied before the set so an issuing instruction that targets the
    // register being written back keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_en && (wb_addr != 5'd0)) begin
            w_busy_nxt[wb_addr] = 1'b0;
        end
        if (flush && (r_state == ST_FULL) && r_rd_wr && (r_rd != 5'd0)) begin
            w_busy_nxt[r_rd] = 1'b0;
        end
        if (w_accept && in_rd_wr && (in_rd != 5'd0)) begin
            w_busy_nxt[in_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_busy  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Output fields only change on accept, so a held entry stays stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op1     <= '0;
            r_op2     <= '0;
            r_rd      <= '0;
            r_rd_wr   <= 1'b0;
            r_payload <= '0;
        end else if (w_accept) begin
            r_op1     <= w_op1;
            r_op2     <= w_op2;
            r_rd      <= in_rd;
            r_rd_wr   <= in_rd_wr;
            r_payload <= in_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (in_valid && w_hazard && !flush && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = (r_state == ST_FULL);
    assign out_op1     = r_op1;
    assign out_op2     = r_op2;
    assign out_rd      = r_rd;
    assign out_rd_wr   = r_rd_wr;
    assign out_payload = r_payload;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// Purpose : directed bench for operand_fetch with a small register-file model.
// Latency : checks registered outputs one cycle after each accept.
// Backpr. : drives out_ready low/high explicitly to exercise the hold and back-to-back paths.
module tb_operand_fetch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_rd_wr;
    logic [31:0] in_payload;
    logic [4:0]  rf_a1;
    logic [4:0]  rf_a2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [4:0]  out_rd;
    logic        out_rd_wr;
    logic [31:0] out_payload;
    logic [15:0] stall_cnt;

    int n_checks;
    int n_pass;

    // Register file model; x0 deliberately reads as all ones so the DUT must force zero.
    logic [31:0] rf [32];
    assign rf_rd1 = rf[rf_a1];
    assign rf_rd2 = rf[rf_a2];

    operand_fetch #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wr(in_rd_wr),
        .in_payload(in_payload),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_wr(out_rd_wr),
        .out_payload(out_payload), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then update the RF model with the write-back that edge committed.
    task automatic tick();
        @(posedge clk);
        #1;
        if (wb_en && (wb_addr != 5'd0)) rf[wb_addr] = wb_data;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rd_wr, input logic [31:0] pl);
        in_valid   = 1'b1;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_rd_wr   = rd_wr;
        in_payload = pl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue(5'd5, 5'd6, 5'd7, 1'b1, 32'h1);
        tick();
        tick();
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("reset_out_op1", out_op1, 32'd0);
        chk("reset_out_payload", out_payload, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        issue(5'd5, 5'd6, 5'd7, 1'b1, 32'hCAFE0001);
        #1;
        chk("basic_rf_a1", {27'd0, rf_a1}, 32'd5);
        chk("basic_rf_a2", {27'd0, rf_a2}, 32'd6);
        chk("basic_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("basic_out_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_out_op1", out_op1, 32'h11);
        chk("basic_out_op2", out_op2, 32'h22);
        chk("basic_out_rd", {27'd0, out_rd}, 32'd7);
        chk("basic_out_rd_wr", {31'd0, out_rd_wr}, 32'd1);
        chk("basic_out_payload", out_payload, 32'hCAFE0001);
    endtask

    task automatic test_raw_stall();
        // x7 is busy from the basic issue; a reader of x7 must wait.
        issue(5'd7, 5'd6, 5'd8, 1'b1, 32'hCAFE0002);
        #1;
        chk("raw_in_ready_stalled", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        tick();
        chk("raw_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        chk("raw_drained", {31'd0, out_valid}, 32'd0);
        wb_en = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'hABCD;
        #1;
        chk("raw_in_ready_bypass", {31'd0, in_ready}, 32'd1);
        tick();
        wb_en = 1'b0;
        in_valid = 1'b0;
        chk("raw_out_valid", {31'd0, out_valid}, 32'd1);
        chk("raw_out_op1_bypass", out_op1, 32'hABCD);
        chk("raw_out_op2", out_op2, 32'h22);
        chk("raw_out_rd", {27'd0, out_rd}, 32'd8);
        chk("raw_stall_cnt_hold", {16'd0, stall_cnt}, 32'd3);
        // x7 released by the write-back; x8 now busy.
        in_rs1 = 5'd7;
        in_rs2 = 5'd0;
        in_rd_wr = 1'b0;
        #1;
        chk("raw_x7_released", {31'd0, in_ready}, 32'd1);
        in_rs1 = 5'd8;
        #1;
        chk("raw_x8_busy", {31'd0, in_ready}, 32'd0);
        wb_en = 1'b1;
        wb_addr = 5'd8;
        wb_data = 32'h88;
        tick();
        wb_en = 1'b0;
        #1;
        chk("raw_x8_released", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic test_x0();
        issue(5'd0, 5'd0, 5'd0, 1'b1, 32'hCAFE0003);
        wb_en = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'h55;
        #1;
        chk("x0_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        wb_en = 1'b0;
        in_valid = 1'b0;
        chk("x0_out_op1", out_op1, 32'd0);
        chk("x0_out_op2", out_op2, 32'd0);
        chk("x0_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        // Reading x0 again right after "writing" it must not stall.
        in_rs1 = 5'd0;
        in_rd_wr = 1'b0;
        #1;
        chk("x0_no_busy", {31'd0, in_ready}, 32'd1);
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        issue(5'd5, 5'd6, 5'd10, 1'b1, 32'h0000000A);
        tick();
        issue(5'd6, 5'd5, 5'd11, 1'b1, 32'h0000000B);
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_payload_stable", out_payload, 32'h0000000A);
            chk("bp_op1_stable", out_op1, 32'h11);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_payload", out_payload, 32'h0000000B);
        chk("b2b_op1", out_op1, 32'h22);
        chk("b2b_op2", out_op2, 32'h11);
        chk("b2b_out_rd", {27'd0, out_rd}, 32'd11);
        tick();
        chk("b2b_drain", {31'd0, out_valid}, 32'd0);
        // WAW: destination x10 still outstanding.
        in_rs1 = 5'd0;
        in_rs2 = 5'd0;
        in_rd = 5'd10;
        in_rd_wr = 1'b1;
        #1;
        chk("waw_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        wb_en = 1'b1;
        wb_addr = 5'd10;
        wb_data = 32'h1010;
        tick();
        wb_addr = 5'd11;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        issue(5'd5, 5'd6, 5'd9, 1'b1, 32'h00000009);
        tick();
        chk("flush_full", {31'd0, out_valid}, 32'd1);
        // Hazardous request during flush: neither accepted nor counted as a stall.
        issue(5'd9, 5'd0, 5'd0, 1'b0, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        #1;
        chk("flush_x9_released", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        issue(5'd5, 5'd6, 5'd12, 1'b1, 32'h0000000C);
        tick();
        issue(5'd12, 5'd0, 5'd0, 1'b0, 32'h0);
        tick();
        chk("rm_stall_cnt", {16'd0, stall_cnt}, 32'd4);
        rst = 1'b1;
        #1;
        chk("rm_in_ready_rst", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rm_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rm_out_op1", out_op1, 32'd0);
        chk("rm_out_op2", out_op2, 32'd0);
        chk("rm_out_payload", out_payload, 32'd0);
        chk("rm_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rm_out_rd_wr", {31'd0, out_rd_wr}, 32'd0);
        chk("rm_stall_cnt_zero", {16'd0, stall_cnt}, 32'd0);
        #1;
        chk("rm_x12_released", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[0] = 32'hFFFFFFFF;
        rf[5] = 32'h11;
        rf[6] = 32'h22;
        rst = 1'b1;
        in_valid = 1'b0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_rd = '0;
        in_rd_wr = 1'b0;
        in_payload = '0;
        wb_en = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        flush = 1'b0;
        out_ready = 1'b1;

        test_reset();
        test_basic();
        test_raw_stall();
        test_x0();
        test_backpressure();
        test_flush();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
